// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment bits are active-low: a 0 lights the segment. Bit order is
// [0]=A, [1]=B, ... [6]=G, so 7'h7F is fully dark.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Number of bits needed to hold values 0..v-1 (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit code to active-low seven-segment pattern.
// In decimal mode codes 10..15 render as a dash so bad BCD is visible.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  // Pure lookup; every case assigns seg so no latch is possible.
  always_comb begin
    case (code)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = hex_mode ? SEG_A : SEG_DASH;
      4'hB:    seg = hex_mode ? SEG_B : SEG_DASH;
      4'hC:    seg = hex_mode ? SEG_C : SEG_DASH;
      4'hD:    seg = hex_mode ? SEG_D : SEG_DASH;
      4'hE:    seg = hex_mode ? SEG_E : SEG_DASH;
      default: seg = hex_mode ? SEG_F : SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed driver for a common-anode seven-segment display.
// A prescaler divides each digit slot; the first P_GUARD cycles of a slot
// keep every digit deselected so the previous digit's pattern cannot ghost.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int P_DIGITS   = 4,
  parameter int P_SCAN_DIV = 50000,
  parameter int P_GUARD    = 16,
  parameter int P_HEX      = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [4*P_DIGITS-1:0] i_data,
  input  logic [P_DIGITS-1:0]   i_dp,
  input  logic                  i_blank_lz,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [P_DIGITS-1:0]   o_sel,
  output logic                  o_frame
);

  localparam int PW = clog2(P_SCAN_DIV);
  localparam int IW = (P_DIGITS > 1) ? clog2(P_DIGITS) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(P_SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(P_DIGITS - 1);
  localparam logic          HEX_MODE = (P_HEX != 0);

  logic [PW-1:0]         psc;
  logic [IW-1:0]         idx;
  logic [4*P_DIGITS-1:0] data_sh;
  logic [P_DIGITS-1:0]   dp_sh;
  logic                  blank_sh;

  logic                  psc_tc;
  logic                  idx_tc;
  logic                  in_guard;
  logic [P_DIGITS-1:0]   blank_vec;
  logic [P_DIGITS-1:0]   sel_n;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            dec_seg;

  assign psc_tc = (psc == PSC_LAST);
  assign idx_tc = (idx == IDX_LAST);

  if (P_GUARD == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    assign in_guard = (psc < PW'(P_GUARD));
  end

  // Shadow registers: capture a whole frame on the load strobe.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_sh  <= '0;
      dp_sh    <= '0;
      blank_sh <= 1'b0;
    end else if (i_load) begin
      data_sh  <= i_data;
      dp_sh    <= i_dp;
      blank_sh <= i_blank_lz;
    end
  end

  // Slot prescaler and digit index; keep running even when disabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      psc <= '0;
      idx <= '0;
    end else if (psc_tc) begin
      psc <= '0;
      idx <= idx_tc ? '0 : idx + IW'(1);
    end else begin
      psc <= psc + PW'(1);
    end
  end

  // Leading-zero mask: digit k blanks when it and every digit above it are zero.
  // NOTE: each always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int k = P_DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run && (data_sh[k*4 +: 4] == 4'd0);
      blank_vec[k] = blank_sh && zero_run;
    end
  end

  // Select the digit under scan and build the active-low select vector.
  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_n     = '1;
    for (int i = 0; i < P_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_code  = data_sh[i*4 +: 4];
        cur_dp    = dp_sh[i];
        cur_blank = blank_vec[i];
        sel_n[i]  = 1'b0;
      end
    end
  end

  seg_hex_decode u_decode (
    .code     (cur_code),
    .hex_mode (HEX_MODE),
    .seg      (dec_seg)
  );

  // Output registers: dark during guard or when disabled; frame pulse on scan wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_seg   <= SEG_BLANK;
      o_dp    <= 1'b1;
      o_sel   <= '1;
      o_frame <= 1'b0;
    end else begin
      o_frame <= psc_tc && idx_tc;
      if (!i_en || in_guard) begin
        o_seg <= SEG_BLANK;
        o_dp  <= 1'b1;
        o_sel <= '1;
      end else begin
        o_seg <= cur_blank ? SEG_BLANK : dec_seg;
        o_dp  <= ~cur_dp;
        o_sel <= sel_n;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench: a cycle-count reference model pushes the expected
// outputs after each clock edge; a monitor pops and compares on the
// falling edge. Two instances cover decimal and hex decode together.
module tb_seg_scan_display;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GUARD  = 2;
  localparam int FRAME  = DIV * DIGITS;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        blank;

  logic [6:0] seg_d, seg_h;
  logic       dp_d, dp_h;
  logic [3:0] sel_d, sel_h;
  logic       frame_d, frame_h;

  always #5 clk = ~clk;

  seg_scan_display #(
    .P_DIGITS(DIGITS), .P_SCAN_DIV(DIV), .P_GUARD(GUARD), .P_HEX(0)
  ) u_dec (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_data(data),
    .i_dp(dp), .i_blank_lz(blank), .o_seg(seg_d), .o_dp(dp_d),
    .o_sel(sel_d), .o_frame(frame_d)
  );

  seg_scan_display #(
    .P_DIGITS(DIGITS), .P_SCAN_DIV(DIV), .P_GUARD(GUARD), .P_HEX(1)
  ) u_hex (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_data(data),
    .i_dp(dp), .i_blank_lz(blank), .o_seg(seg_h), .o_dp(dp_h),
    .o_sel(sel_h), .o_frame(frame_h)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg_dec;
    logic [6:0] seg_hex;
    logic       dp;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [6:0] tbl_dec [16];
  logic [6:0] tbl_hex [16];

  initial begin
    tbl_dec = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    tbl_hex = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Reference model: elapsed cycles since reset define slot and digit.
  int          tick;
  int          slot;
  int          dig;
  int          code;
  logic        blanked;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic        m_blank;
  exp_t        e;

  always @(posedge clk) begin
    e = '{sel: 4'hF, seg_dec: 7'h7F, seg_hex: 7'h7F, dp: 1'b1, frame: 1'b0};
    if (rst) begin
      tick    = 0;
      m_data  = '0;
      m_dp    = '0;
      m_blank = 1'b0;
    end else begin
      slot    = tick % DIV;
      dig     = (tick / DIV) % DIGITS;
      e.frame = ((tick % FRAME) == FRAME - 1);
      if (en && slot >= GUARD) begin
        code      = int'((m_data >> (4 * dig)) & 16'hF);
        blanked   = m_blank && (dig > 0) && ((m_data >> (4 * dig)) == 16'd0);
        e.sel     = ~(4'b0001 << dig);
        e.seg_dec = blanked ? 7'h7F : tbl_dec[code];
        e.seg_hex = blanked ? 7'h7F : tbl_hex[code];
        e.dp      = ~m_dp[dig];
      end
      if (load) begin
        m_data  = data;
        m_dp    = dp;
        m_blank = blank;
      end
      tick++;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare both instances against each expected entry.
  exp_t got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = '{sel: sel_d, seg_dec: seg_d, seg_hex: seg_h, dp: dp_d, frame: frame_d};
      check("dec_outputs", 32'(got), 32'(e));
      check("hex_sel_dp_frame", {24'd0, sel_h, dp_h, frame_h},
            {24'd0, e.sel, e.dp, e.frame});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic b);
    @(negedge clk);
    data  = d;
    dp    = p;
    blank = b;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] d;
    d = 16'($urandom);
    for (int n = 0; n < 4; n++)
      if ($urandom_range(1, 0) == 0) d[n*4 +: 4] = 4'h0;
    return d;
  endfunction

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    load  = 1'b0;
    data  = '0;
    dp    = '0;
    blank = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(40);

    do_load(16'h1234, 4'b0100, 1'b0);
    cycles(70);
    do_load(16'hA0F5, 4'b0000, 1'b0);
    cycles(40);
    do_load(16'h0007, 4'b0010, 1'b1);
    cycles(40);
    do_load(16'h0000, 4'b0000, 1'b1);
    cycles(40);

    do_load(16'h9876, 4'b1001, 1'b0);
    cycles(13);
    en = 1'b0;
    cycles(21);
    en = 1'b1;
    cycles(40);

    // Reset mid-scan with a simultaneous load: the load must be dropped.
    cycles(5);
    @(negedge clk);
    rst   = 1'b1;
    load  = 1'b1;
    data  = 16'hFFFF;
    dp    = 4'hF;
    blank = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    cycles(40);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      load  = ($urandom_range(7, 0) == 0);
      data  = rand_data();
      dp    = 4'($urandom);
      blank = 1'($urandom);
      en    = ($urandom_range(9, 0) != 0);
      rst   = ($urandom_range(199, 0) == 0);
    end
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    en   = 1'b1;
    cycles(10);

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
